// File: rtl/sha256_block_ctrl.sv
// SHA-256 single-block compression sequencer with its round operator; optional SHA256_CHAIN_EN adds a `chain` input.
// Latency: 65 cycles start-to-done; 64 rounds plus one finalisation cycle; one block per 66 cycles back-to-back.
// Backpressure: none; start is only sampled in IDLE, and a start while busy is dropped rather than queued.

// One SHA-256 round: combinational, owns the K table; passes the state through when disabled.
module sha256_round (
  input  logic         en_i,
  input  logic [255:0] state_i,
  input  logic [31:0]  w_i,
  input  logic [5:0]   t_i,
  output logic [255:0] state_o
);

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] t);
    logic [31:0] k;
    case (t)
      6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; default: k = 32'hc67178f2;
    endcase
    return k;
  endfunction

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_i;

  // Compression round: T1/T2 and the register rotation, bypassed when not enabled.
  always_comb begin
    t1 = h + (ror32(e, 6) ^ ror32(e, 11) ^ ror32(e, 25)) + ((e & f) ^ (~e & g)) + k_rom(t_i) + w_i;
    t2 = (ror32(a, 2) ^ ror32(a, 13) ^ ror32(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    if (en_i) begin
      state_o = {t1 + t2, a, b, c, d + t1, e, f, g};
    end else begin
      state_o = state_i;
    end
  end

endmodule

module sha256_block_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] block,
  input  logic [255:0] hash_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out
`ifdef SHA256_CHAIN_EN
  ,
  input  logic         chain
`endif
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t       state_q;
  logic [6:0]   t_q;
  logic [255:0] work_q, work_d;
  logic [255:0] hcap_q;
  logic [511:0] win_q, win_d;
  logic [255:0] hash_q, digest_d;
  logic         busy_q, done_q;
  logic [255:0] init_val;
  logic [31:0]  w_new;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
  endfunction

`ifdef SHA256_CHAIN_EN
  // Chaining reuses the last digest so multi-block messages need no external feedback.
  assign init_val = chain ? hash_q : hash_in;
`else
  assign init_val = hash_in;
`endif

  sha256_round u_round (
    .en_i    (state_q == ROUND),
    .state_i (work_q),
    .w_i     (win_q[511:480]),
    .t_i     (t_q[5:0]),
    .state_o (work_d)
  );

  // Schedule window: W0 sits in the top word; the window shifts up and the new word enters at W15.
  always_comb begin
    w_new = sig1(win_q[63:32]) + win_q[223:192] + sig0(win_q[479:448]) + win_q[511:480];
    win_d = {win_q[479:0], w_new};
  end

  // Final feed-forward: independent 32-bit adds of captured chaining value and working state.
  always_comb begin
    digest_d = '0;
    for (int i = 0; i < 8; i++) begin
      digest_d[i*32 +: 32] = hcap_q[i*32 +: 32] + work_q[i*32 +: 32];
    end
  end

  // Control FSM and all datapath registers; outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      work_q  <= '0;
      hcap_q  <= '0;
      win_q   <= '0;
      hash_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ROUND;
            busy_q  <= 1'b1;
            work_q  <= init_val;
            hcap_q  <= init_val;
            win_q   <= block;
            t_q     <= '0;
          end
        end
        ROUND: begin
          work_q <= work_d;
          win_q  <= win_d;
          t_q    <= t_q + 7'd1;
          if (t_q == 7'd63) begin
            state_q <= FINAL;
          end
        end
        FINAL: begin
          hash_q  <= digest_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hash_out = hash_q;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Self-checking bench for sha256_block_ctrl: known-answer vectors plus random blocks against a textbook SHA-256 model.
// Checks 65-cycle latency, done pulse width, ignored start while busy, reset abort and digest hold.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_sha256_block_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [511:0] block;
  logic [255:0] hash_in;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;
`ifdef SHA256_CHAIN_EN
  logic         chain_in;
`endif

  int errors = 0;
  int checks = 0;
  logic [255:0] prev_exp;

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_block_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .block    (block),
    .hash_in  (hash_in),
    .busy     (busy),
    .done     (done),
    .hash_out (hash_out)
`ifdef SHA256_CHAIN_EN
    ,
    .chain    (chain_in)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression: full 64-word schedule array, then 64 rounds, then feed-forward.
  function automatic logic [255:0] sha_ref(input logic [511:0] blk, input logic [255:0] hv);
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) begin
      h[i] = hv[255 - 32*i -: 32];
      v[i] = h[i];
    end
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h[i] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [255:0] rand_hash();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  // Start one block and wait for done; ch means "continue from the previous digest".
  // poke_at > 0 re-pulses start with junk so it is sampled at edge N+poke_at.
  task automatic do_block(input string tag, input logic [511:0] blk, input logic [255:0] hin,
                          input bit ch, input logic [255:0] exp, input int poke_at);
    int n;
    block = blk;
`ifdef SHA256_CHAIN_EN
    chain_in = ch;
    hash_in  = hin;
`else
    hash_in  = ch ? prev_exp : hin;
`endif
    start = 1'b1;
    tick();
    start   = 1'b0;
    block   = rand_block();
    hash_in = rand_hash();
`ifdef SHA256_CHAIN_EN
    chain_in = 1'b0;
`endif
    chk({tag, "_busy"}, 256'(busy), 256'(1'b1));
    chk({tag, "_done_low"}, 256'(done), 256'(1'b0));
    chk({tag, "_hold"}, hash_out, prev_exp);
    n = 0;
    while (!done && n < 200) begin
      start = (n == poke_at - 1);
      tick();
      start = 1'b0;
      n++;
    end
    chk({tag, "_latency"}, 256'(n), 256'(65));
    chk({tag, "_busy_end"}, 256'(busy), 256'(1'b0));
    chk({tag, "_digest"}, hash_out, exp);
    prev_exp = exp;
  endtask

  initial begin
    logic [511:0] b;
    logic [255:0] h, e, abc_d;
    logic [511:0] abc_blk, empty_blk, two1, two2;
    int n;
    bit saw_done;

    abc_blk   = {32'h61626380, 448'h0, 32'h00000018};
    empty_blk = {32'h80000000, 480'h0};
    two1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
            32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two2 = {480'h0, 32'h000001c0};
    abc_d = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    reset = 1'b1; start = 1'b0; block = '0; hash_in = '0; prev_exp = '0;
`ifdef SHA256_CHAIN_EN
    chain_in = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_busy", 256'(busy), 256'(1'b0));
    chk("rst_done", 256'(done), 256'(1'b0));
    chk("rst_hash", hash_out, 256'h0);

    do_block("abc", abc_blk, IV, 1'b0, abc_d, 0);
    do_block("empty", empty_blk, IV, 1'b0,
             256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, 0);

    e = sha_ref(two1, IV);
    do_block("two_1", two1, IV, 1'b0, e, 0);
    do_block("two_2", two2, rand_hash(), 1'b1,
             256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, 0);

    do_block("abc_poke", abc_blk, IV, 1'b0, abc_d, 10);
    tick();
    chk("poke_done_fall", 256'(done), 256'(1'b0));
    chk("poke_idle", 256'(busy), 256'(1'b0));

    for (int k = 0; k < 6; k++) begin
      b = rand_block();
      h = rand_hash();
      do_block($sformatf("rnd%0d", k), b, h, 1'b0, sha_ref(b, h), 0);
    end

    // Abort mid-block with reset, then restart the same block.
    block = abc_blk; hash_in = IV; start = 1'b1;
`ifdef SHA256_CHAIN_EN
    chain_in = 1'b0;
`endif
    tick();
    start = 1'b0;
    saw_done = 1'b0;
    for (n = 1; n < 30; n++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (done) saw_done = 1'b1;
    chk("abort_no_done", 256'(saw_done), 256'(1'b0));
    chk("abort_busy", 256'(busy), 256'(1'b0));
    chk("abort_hash", hash_out, 256'h0);
    prev_exp = '0;
    tick();
    do_block("abc_restart", abc_blk, IV, 1'b0, abc_d, 0);
    tick();
    chk("final_done_fall", 256'(done), 256'(1'b0));
    chk("final_hold", hash_out, abc_d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
